jk_sequence_checker: RTL and testbench

Receive-side checker for the 4-bit JK counter stream. The counter steps through the seven-code cycle 0, 1, 3, 5, 7, 11, 13 and back to 0. This block samples that stream and decodes each code to its sequence position. It acquires and holds lock on the expected order and flags every departure from it. It sits downstream of the counter's `Count` output, as a monitor or as the consumer of that output.

---
 rtl/jk_sequence_checker.sv | 193 +++++++++++++++++++
 tb/tb_jk_sequence_checker.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/jk_sequence_checker.sv
//==============================================================================
// Module   : jk_sequence_checker
// Purpose  : Lock/monitor for the 7-code JK counter stream (0,1,3,5,7,11,13).
//            Optional JK_CHECKER_ERRCNT_EN enables the saturating error counter.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module jk_sequence_checker #(
    parameter int LOCK_COUNT = 3,
    parameter int LOSS_COUNT = 2,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             code_valid,
    input  logic [3:0]       code_in,
    output logic [2:0]       index,
    output logic             index_valid,
    output logic             locked,
    output logic             seq_err,
    output logic             illegal,
    output logic             wrap,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [1:0] ST_HUNT   = 2'd0;
    localparam logic [1:0] ST_ACQ    = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam logic [2:0] LOCK_TGT = 3'(LOCK_COUNT);
    localparam logic [2:0] LOSS_TGT = 3'(LOSS_COUNT);

    logic [1:0] state, state_nxt;
    logic [2:0] expected, expected_nxt;
    logic [2:0] match_cnt, match_nxt;
    logic [2:0] miss_cnt, miss_nxt;

    logic       code_legal;
    logic [2:0] code_idx;
    logic       matched;

    logic [2:0] index_nxt;
    logic       index_valid_nxt;
    logic       seq_err_nxt;
    logic       illegal_nxt;
    logic       wrap_nxt;

    // Sequence positions are tracked as indices 0..6, so the successor is a mod-7 increment.
    function automatic logic [2:0] next_idx(input logic [2:0] i);
        return (i == 3'd6) ? 3'd0 : i + 3'd1;
    endfunction

    always_comb begin
        code_legal = 1'b1;
        code_idx   = 3'd0;
        case (code_in)
            4'd0:    code_idx = 3'd0;
            4'd1:    code_idx = 3'd1;
            4'd3:    code_idx = 3'd2;
            4'd5:    code_idx = 3'd3;
            4'd7:    code_idx = 3'd4;
            4'd11:   code_idx = 3'd5;
            4'd13:   code_idx = 3'd6;
            default: code_legal = 1'b0;
        endcase
    end

    assign matched = code_legal && (code_idx == expected);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_HUNT;
            expected  <= 3'd0;
            match_cnt <= 3'd0;
            miss_cnt  <= 3'd0;
        end else begin
            state     <= state_nxt;
            expected  <= expected_nxt;
            match_cnt <= match_nxt;
            miss_cnt  <= miss_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt    = state;
        expected_nxt = expected;
        match_nxt    = match_cnt;
        miss_nxt     = miss_cnt;
        if (code_valid) begin
            case (state)
                ST_HUNT: begin
                    if (code_legal) begin
                        state_nxt    = ST_ACQ;
                        expected_nxt = next_idx(code_idx);
                        match_nxt    = 3'd0;
                    end
                end
                ST_ACQ: begin
                    if (!code_legal) begin
                        state_nxt = ST_HUNT;
                        match_nxt = 3'd0;
                    end else if (matched) begin
                        match_nxt    = match_cnt + 3'd1;
                        expected_nxt = next_idx(code_idx);
                        if (match_cnt + 3'd1 == LOCK_TGT) begin
                            state_nxt = ST_LOCKED;
                            miss_nxt  = 3'd0;
                        end
                    end else begin
                        // Legal but out of order: restart acquisition from this code.
                        match_nxt    = 3'd0;
                        expected_nxt = next_idx(code_idx);
                    end
                end
                ST_LOCKED: begin
                    if (matched) begin
                        expected_nxt = next_idx(code_idx);
                        miss_nxt     = 3'd0;
                    end else begin
                        expected_nxt = next_idx(expected);
                        miss_nxt     = miss_cnt + 3'd1;
                        if (miss_cnt + 3'd1 == LOSS_TGT) begin
                            state_nxt = ST_HUNT;
                            match_nxt = 3'd0;
                            miss_nxt  = 3'd0;
                        end
                    end
                end
                default: begin
                    state_nxt = ST_HUNT;
                    match_nxt = 3'd0;
                    miss_nxt  = 3'd0;
                end
            endcase
        end
    end

    // Output logic (next values of the registered outputs)
    always_comb begin
        index_nxt       = index;
        index_valid_nxt = index_valid;
        seq_err_nxt     = 1'b0;
        illegal_nxt     = 1'b0;
        wrap_nxt        = 1'b0;
        if (code_valid) begin
            if (code_legal) begin
                index_nxt       = code_idx;
                index_valid_nxt = 1'b1;
            end
            illegal_nxt = !code_legal;
            if (state == ST_LOCKED) begin
                seq_err_nxt = !matched;
                wrap_nxt    = matched && (code_idx == 3'd0);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            index       <= 3'd0;
            index_valid <= 1'b0;
            seq_err     <= 1'b0;
            illegal     <= 1'b0;
            wrap        <= 1'b0;
        end else begin
            index       <= index_nxt;
            index_valid <= index_valid_nxt;
            seq_err     <= seq_err_nxt;
            illegal     <= illegal_nxt;
            wrap        <= wrap_nxt;
        end
    end

    assign locked = (state == ST_LOCKED);

`ifdef JK_CHECKER_ERRCNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_count <= '0;
        end else if (seq_err_nxt && (err_count != {ERR_W{1'b1}})) begin
            err_count <= err_count + {{(ERR_W-1){1'b0}}, 1'b1};
        end
    end
`else
    assign err_count = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_jk_sequence_checker.sv
//==============================================================================
// Module   : tb_jk_sequence_checker
// Purpose  : Directed self-checking bench for jk_sequence_checker (ERR_W 8 and 2).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_jk_sequence_checker;

    logic       clk = 1'b0;
    logic       reset;
    logic       code_valid;
    logic [3:0] code_in;

    logic [2:0] index, index2;
    logic       index_valid, index_valid2;
    logic       locked, locked2;
    logic       seq_err, seq_err2;
    logic       illegal, illegal2;
    logic       wrap, wrap2;
    logic [7:0] err_count;
    logic [1:0] err_count2;

    int tests  = 0;
    int failed = 0;

    jk_sequence_checker dut (
        .clk(clk), .reset(reset), .code_valid(code_valid), .code_in(code_in),
        .index(index), .index_valid(index_valid), .locked(locked),
        .seq_err(seq_err), .illegal(illegal), .wrap(wrap), .err_count(err_count)
    );

    jk_sequence_checker #(.ERR_W(2)) dut2 (
        .clk(clk), .reset(reset), .code_valid(code_valid), .code_in(code_in),
        .index(index2), .index_valid(index_valid2), .locked(locked2),
        .seq_err(seq_err2), .illegal(illegal2), .wrap(wrap2), .err_count(err_count2)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before 100000 ns");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // e_err is the raw number of seq_err events since reset.
    task automatic check_outs(input string tag, input logic [2:0] e_idx, input logic e_iv,
                              input logic e_lk, input logic e_se, input logic e_il,
                              input logic e_wr, input int e_err);
        int ec, ec2;
`ifdef JK_CHECKER_ERRCNT_EN
        ec  = (e_err > 255) ? 255 : e_err;
        ec2 = (e_err > 3) ? 3 : e_err;
`else
        ec  = 0;
        ec2 = 0;
`endif
        chk({tag, " index"},       32'(index),       32'(e_idx));
        chk({tag, " index_valid"}, 32'(index_valid), 32'(e_iv));
        chk({tag, " locked"},      32'(locked),      32'(e_lk));
        chk({tag, " seq_err"},     32'(seq_err),     32'(e_se));
        chk({tag, " illegal"},     32'(illegal),     32'(e_il));
        chk({tag, " wrap"},        32'(wrap),        32'(e_wr));
        chk({tag, " err_count"},   32'(err_count),   32'(ec));
        chk({tag, " locked2"},     32'(locked2),     32'(e_lk));
        chk({tag, " err_count2"},  32'(err_count2),  32'(ec2));
    endtask

    task automatic send(input logic [3:0] c);
        @(negedge clk);
        code_valid = 1'b1;
        code_in    = c;
        @(posedge clk);
        #1;
        code_valid = 1'b0;
    endtask

    initial begin
        reset      = 1'b0;
        code_valid = 1'b0;
        code_in    = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset", 3'd0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;

        // Clean cycle: lock on the 4th code, wrap on the final 0
        send(4'd0);  check_outs("p1_c0",  3'd0, 1, 0, 0, 0, 0, 0);
        send(4'd1);  check_outs("p1_c1",  3'd1, 1, 0, 0, 0, 0, 0);
        send(4'd3);  check_outs("p1_c3",  3'd2, 1, 0, 0, 0, 0, 0);
        send(4'd5);  check_outs("p1_c5",  3'd3, 1, 1, 0, 0, 0, 0);
        send(4'd7);  check_outs("p1_c7",  3'd4, 1, 1, 0, 0, 0, 0);
        send(4'd11); check_outs("p1_c11", 3'd5, 1, 1, 0, 0, 0, 0);
        send(4'd13); check_outs("p1_c13", 3'd6, 1, 1, 0, 0, 0, 0);
        send(4'd0);  check_outs("p1_c0w", 3'd0, 1, 1, 0, 0, 1, 0);

        // Illegal 9 inside lock: flywheel keeps lock
        send(4'd1);  check_outs("p2_c1",  3'd1, 1, 1, 0, 0, 0, 0);
        send(4'd3);  check_outs("p2_c3",  3'd2, 1, 1, 0, 0, 0, 0);
        send(4'd5);  check_outs("p2_c5",  3'd3, 1, 1, 0, 0, 0, 0);
        send(4'd7);  check_outs("p2_c7",  3'd4, 1, 1, 0, 0, 0, 0);
        send(4'd9);  check_outs("p2_c9",  3'd4, 1, 1, 1, 1, 0, 1);
        send(4'd13); check_outs("p2_c13", 3'd6, 1, 1, 0, 0, 0, 1);
        send(4'd0);  check_outs("p2_c0",  3'd0, 1, 1, 0, 0, 1, 1);

        // Gap in code_valid: nothing changes, pulses low
        @(negedge clk);
        code_valid = 1'b0;
        @(posedge clk);
        #1;
        check_outs("gap", 3'd0, 1, 1, 0, 0, 0, 1);

        // Lock loss: expected 7, feed 3,3
        send(4'd1);  check_outs("p3_c1",  3'd1, 1, 1, 0, 0, 0, 1);
        send(4'd3);  check_outs("p3_c3",  3'd2, 1, 1, 0, 0, 0, 1);
        send(4'd5);  check_outs("p3_c5",  3'd3, 1, 1, 0, 0, 0, 1);
        send(4'd3);  check_outs("p3_m1",  3'd2, 1, 1, 1, 0, 0, 2);
        send(4'd3);  check_outs("p3_m2",  3'd2, 1, 0, 1, 0, 0, 3);

        // Re-acquire with a re-anchor on 7
        send(4'd0);  check_outs("p4_c0",  3'd0, 1, 0, 0, 0, 0, 3);
        send(4'd1);  check_outs("p4_c1",  3'd1, 1, 0, 0, 0, 0, 3);
        send(4'd7);  check_outs("p4_c7",  3'd4, 1, 0, 0, 0, 0, 3);
        send(4'd11); check_outs("p4_c11", 3'd5, 1, 0, 0, 0, 0, 3);
        send(4'd13); check_outs("p4_c13", 3'd6, 1, 0, 0, 0, 0, 3);
        send(4'd0);  check_outs("p4_c0l", 3'd0, 1, 1, 0, 0, 0, 3);

        // Two isolated mismatches while locked: err_count reaches 5, ERR_W=2 saturates
        send(4'd2);  check_outs("p5_c2",  3'd0, 1, 1, 1, 1, 0, 4);
        send(4'd3);  check_outs("p5_c3",  3'd2, 1, 1, 0, 0, 0, 4);
        send(4'd7);  check_outs("p5_m7",  3'd4, 1, 1, 1, 0, 0, 5);
        send(4'd7);  check_outs("p5_c7",  3'd4, 1, 1, 0, 0, 0, 5);

        // Asynchronous reset mid-cycle, with priority over a concurrent sample
        #2;
        reset = 1'b0;
        #1;
        check_outs("async_rst", 3'd0, 0, 0, 0, 0, 0, 0);
        code_valid = 1'b1;
        code_in    = 4'd0;
        @(posedge clk);
        #1;
        check_outs("rst_prio", 3'd0, 0, 0, 0, 0, 0, 0);
        code_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        // Illegal in HUNT leaves index_valid low; then 0,1,3,5 relocks
        send(4'd4);  check_outs("p6_c4",  3'd0, 0, 0, 0, 1, 0, 0);
        send(4'd0);  check_outs("p6_c0",  3'd0, 1, 0, 0, 0, 0, 0);
        send(4'd1);  check_outs("p6_c1",  3'd1, 1, 0, 0, 0, 0, 0);
        send(4'd3);  check_outs("p6_c3",  3'd2, 1, 0, 0, 0, 0, 0);
        send(4'd5);  check_outs("p6_c5",  3'd3, 1, 1, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

`default_nettype wire
